// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory slice:
// loader FSM states, special instruction words and field widths.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } ld_state_e;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  localparam int OPC_W   = 6;
  localparam int REG_W   = 5;
  localparam int SHAMT_W = 5;
  localparam int FUNCT_W = 6;
  localparam int IMM_W   = 16;
  localparam int JADDR_W = 26;

endpackage

// File: rtl/instr_ram.sv
// One write port, one registered read port instruction RAM.
// Contents are never reset; only the read register is.
module instr_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_q <= '0;
    else if (i_re)
      r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: streaming program load port plus a
// one-cycle registered fetch port with range/alignment fault reporting.
module instr_mem_loadable
  import mips_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 32,
  parameter int BYTE_ADDR = 0,
  parameter logic [DATA_W-1:0] HALT_INSTR = DATA_W'(HALT_WORD)
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       Ld_start,
  input  logic                       Ld_valid,
  input  logic [DATA_W-1:0]          Ld_data,
  input  logic                       Ld_last,
  output logic                       Ld_busy,
  output logic                       Ld_overflow,
  output logic [$clog2(DEPTH):0]     Prog_len,
  input  logic                       Fetch_req,
  input  logic [ADDR_W-1:0]          Fetch_addr,
  output logic                       Fetch_ready,
  output logic                       Fetch_valid,
  output logic [DATA_W-1:0]          InstrOut,
  output logic                       Fetch_fault
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  ld_state_e         r_state;
  ld_state_e         w_nxt;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_prog_len;
  logic              r_ovf;
  logic              r_valid;
  logic              r_fault;

  logic              w_ld_word;
  logic              w_room;
  logic              w_we;
  logic [PW-1:0]     w_len_next;
  logic [ADDR_W-1:0] w_idx;
  logic              w_misal;
  logic              w_oor;
  logic              w_fault;
  logic              w_accept;
  logic              w_re;
  logic [DATA_W-1:0] w_rdata;

  // A word is taken only in LOAD, and never in the cycle of a restart.
  assign w_ld_word  = (r_state == ST_LOAD) && Ld_valid && !Ld_start;
  assign w_room     = (r_ptr < PW'(DEPTH));
  assign w_we       = w_ld_word && w_room;
  assign w_len_next = w_room ? (r_ptr + PW'(1)) : PW'(DEPTH);

  always_comb begin
    w_nxt = r_state;
    if (Ld_start) begin
      w_nxt = ST_LOAD;
    end else begin
      unique case (r_state)
        ST_EMPTY: w_nxt = ST_EMPTY;
        ST_LOAD:  if (Ld_valid && Ld_last) w_nxt = ST_READY;
        ST_READY: w_nxt = ST_READY;
        default:  w_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= ST_EMPTY;
      r_ptr      <= '0;
      r_prog_len <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (Ld_start) begin
        r_ptr <= '0;
        r_ovf <= 1'b0;
      end else if (w_ld_word) begin
        if (w_room)
          r_ptr <= r_ptr + PW'(1);
        else
          r_ovf <= 1'b1;
        if (Ld_last)
          r_prog_len <= w_len_next;
      end
    end
  end

  // Full-width compares so large addresses never alias into the array.
  assign w_idx    = (BYTE_ADDR != 0) ? (Fetch_addr >> 2) : Fetch_addr;
  assign w_misal  = (BYTE_ADDR != 0) && (Fetch_addr[1:0] != 2'b00);
  assign w_oor    = (w_idx >= ADDR_W'(r_prog_len)) ||
                    (w_idx >= ADDR_W'(DEPTH));
  assign w_fault  = w_oor || w_misal;

  assign Fetch_ready = (r_state == ST_READY) && !Ld_start;
  assign w_accept    = Fetch_req && Fetch_ready;
  assign w_re        = w_accept && !w_fault;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_valid <= w_accept;
      if (w_accept)
        r_fault <= w_fault;
    end
  end

  instr_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .i_clk   (Clk),
    .i_rst_n (Rst_n),
    .i_we    (w_we),
    .i_waddr (r_ptr[AW-1:0]),
    .i_wdata (Ld_data),
    .i_re    (w_re),
    .i_raddr (w_idx[AW-1:0]),
    .o_rdata (w_rdata)
  );

  assign Ld_busy     = (r_state == ST_LOAD);
  assign Ld_overflow = r_ovf;
  assign Prog_len    = r_prog_len;
  assign Fetch_valid = r_valid;
  assign Fetch_fault = r_fault;
  assign InstrOut    = r_fault ? HALT_INSTR : w_rdata;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench: a default word-addressed instance and a
// DEPTH=4 byte-addressed instance driven from fixed vectors.
module tb_instr_mem_loadable;

  logic clk;
  logic rst_n;

  logic        a_start, a_valid, a_last, a_req;
  logic [31:0] a_data, a_addr;
  logic        a_busy, a_ovf, a_ready, a_fv, a_ff;
  logic [6:0]  a_len;
  logic [31:0] a_instr;

  logic        b_start, b_valid, b_last, b_req;
  logic [31:0] b_data, b_addr;
  logic        b_busy, b_ovf, b_ready, b_fv, b_ff;
  logic [2:0]  b_len;
  logic [31:0] b_instr;

  int n_cmp = 0;
  int n_err = 0;

  instr_mem_loadable u_a (
    .Clk(clk), .Rst_n(rst_n),
    .Ld_start(a_start), .Ld_valid(a_valid), .Ld_data(a_data),
    .Ld_last(a_last), .Ld_busy(a_busy), .Ld_overflow(a_ovf),
    .Prog_len(a_len), .Fetch_req(a_req), .Fetch_addr(a_addr),
    .Fetch_ready(a_ready), .Fetch_valid(a_fv),
    .InstrOut(a_instr), .Fetch_fault(a_ff)
  );

  instr_mem_loadable #(.DEPTH(4), .BYTE_ADDR(1)) u_b (
    .Clk(clk), .Rst_n(rst_n),
    .Ld_start(b_start), .Ld_valid(b_valid), .Ld_data(b_data),
    .Ld_last(b_last), .Ld_busy(b_busy), .Ld_overflow(b_ovf),
    .Prog_len(b_len), .Fetch_req(b_req), .Fetch_addr(b_addr),
    .Fetch_ready(b_ready), .Fetch_valid(b_fv),
    .InstrOut(b_instr), .Fetch_fault(b_ff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        fault;
  } fvec_t;

  logic [31:0] prog [8];
  logic [31:0] bw   [6];
  fvec_t       tva  [11];
  fvec_t       tvb  [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic a_word(input logic [31:0] d, input logic last);
    a_valid = 1'b1;
    a_data  = d;
    a_last  = last;
    tick();
    a_valid = 1'b0;
    a_last  = 1'b0;
  endtask

  task automatic b_word(input logic [31:0] d, input logic last);
    b_valid = 1'b1;
    b_data  = d;
    b_last  = last;
    tick();
    b_valid = 1'b0;
    b_last  = 1'b0;
  endtask

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  initial begin
    prog[0] = 32'h0401_1806; prog[1] = 32'h0402_280A;
    prog[2] = 32'h4022_1807; prog[3] = 32'h0000_0013;
    prog[4] = 32'h1234_5678; prog[5] = 32'hDEAD_BEEF;
    prog[6] = 32'h0BAD_F00D; prog[7] = 32'hCAFE_0001;
    for (int i = 0; i < 8; i++)
      tva[i] = '{addr: i, data: prog[i], fault: 1'b0};
    tva[8]  = '{addr: 32'd8,         data: HALT,    fault: 1'b1};
    tva[9]  = '{addr: 32'h8000_0000, data: HALT,    fault: 1'b1};
    tva[10] = '{addr: 32'd3,         data: prog[3], fault: 1'b0};

    for (int i = 0; i < 6; i++) bw[i] = 32'hB000_0000 + i;
    tvb[0] = '{addr: 32'h8,  data: bw[2], fault: 1'b0};
    tvb[1] = '{addr: 32'h6,  data: HALT,  fault: 1'b1};
    tvb[2] = '{addr: 32'hC,  data: bw[3], fault: 1'b0};
    tvb[3] = '{addr: 32'h10, data: HALT,  fault: 1'b1};
    tvb[4] = '{addr: 32'h0,  data: bw[0], fault: 1'b0};

    {a_start, a_valid, a_last, a_req} = '0;
    {b_start, b_valid, b_last, b_req} = '0;
    a_data = '0; a_addr = '0; b_data = '0; b_addr = '0;
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_len", 32'(a_len), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_ovf", 32'(a_ovf), 32'd0);
    chk("rst_fv", 32'(a_fv), 32'd0);
    chk("rst_instr", a_instr, 32'd0);
    rst_n = 1'b1;
    tick();

    // Fetch while EMPTY: not accepted, nothing returned
    a_req = 1'b1; a_addr = 32'd0;
    #1;
    chk("empty_ready", 32'(a_ready), 32'd0);
    tick();
    chk("empty_fv", 32'(a_fv), 32'd0);
    chk("empty_len", 32'(a_len), 32'd0);
    a_req = 1'b0;

    // 8-word load
    a_start = 1'b1; tick(); a_start = 1'b0;
    chk("ld_busy", 32'(a_busy), 32'd1);
    for (int i = 0; i < 8; i++) a_word(prog[i], i == 7);
    chk("ld8_len", 32'(a_len), 32'd8);
    chk("ld8_busy", 32'(a_busy), 32'd0);
    chk("ld8_ready", 32'(a_ready), 32'd1);

    // Back-to-back fetch table
    a_req = 1'b1;
    for (int i = 0; i < 11; i++) begin
      a_addr = tva[i].addr;
      tick();
      chk($sformatf("fa%0d_fv", i), 32'(a_fv), 32'd1);
      chk($sformatf("fa%0d_data", i), a_instr, tva[i].data);
      chk($sformatf("fa%0d_fault", i), 32'(a_ff), 32'(tva[i].fault));
    end
    a_req = 1'b0;
    tick();
    chk("idle_fv", 32'(a_fv), 32'd0);
    chk("idle_hold", a_instr, prog[3]);

    // Ld_start right after an accepted fetch
    a_req = 1'b1; a_addr = 32'd5;
    tick();
    a_start = 1'b1;
    #1;
    chk("rs_ready", 32'(a_ready), 32'd0);
    chk("rs_fv", 32'(a_fv), 32'd1);
    chk("rs_data", a_instr, prog[5]);
    tick();
    a_start = 1'b0; a_req = 1'b0;
    chk("rs_fv2", 32'(a_fv), 32'd0);
    chk("rs_busy", 32'(a_busy), 32'd1);
    chk("rs_len_keep", 32'(a_len), 32'd8);
    a_word(32'hAAAA_0000, 1'b0);
    a_word(32'hBBBB_0001, 1'b1);
    chk("ld2_len", 32'(a_len), 32'd2);
    a_req = 1'b1; a_addr = 32'd1;
    tick();
    chk("ld2_f1", a_instr, 32'hBBBB_0001);
    chk("ld2_f1_fault", 32'(a_ff), 32'd0);
    a_addr = 32'd2;
    tick();
    chk("ld2_f2", a_instr, HALT);
    chk("ld2_f2_fault", 32'(a_ff), 32'd1);
    a_req = 1'b0;

    // DEPTH=4 byte-addressed instance: overflow and alignment
    b_start = 1'b1; tick(); b_start = 1'b0;
    for (int i = 0; i < 6; i++) b_word(bw[i], i == 5);
    chk("b_ovf", 32'(b_ovf), 32'd1);
    chk("b_len", 32'(b_len), 32'd4);
    chk("b_ready", 32'(b_ready), 32'd1);
    b_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_addr = tvb[i].addr;
      tick();
      chk($sformatf("fb%0d_fv", i), 32'(b_fv), 32'd1);
      chk($sformatf("fb%0d_data", i), b_instr, tvb[i].data);
      chk($sformatf("fb%0d_fault", i), 32'(b_ff), 32'(tvb[i].fault));
    end
    b_req = 1'b0;
    // Restart coinciding with a last word: restart wins
    b_start = 1'b1; b_valid = 1'b1; b_last = 1'b1; b_data = 32'h1;
    tick();
    b_start = 1'b0; b_valid = 1'b0; b_last = 1'b0;
    chk("b_ovf_clr", 32'(b_ovf), 32'd0);
    chk("b_same_busy", 32'(b_busy), 32'd1);
    chk("b_same_len", 32'(b_len), 32'd4);

    // Reset in the middle of a load
    a_start = 1'b1; tick(); a_start = 1'b0;
    for (int i = 0; i < 3; i++) a_word(prog[i], 1'b0);
    chk("mid_busy", 32'(a_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_busy", 32'(a_busy), 32'd0);
    chk("mr_len", 32'(a_len), 32'd0);
    chk("mr_fv", 32'(a_fv), 32'd0);
    chk("mr_instr", a_instr, 32'd0);
    chk("mr_ready", 32'(a_ready), 32'd0);
    chk("mr_b_len", 32'(b_len), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_busy", 32'(a_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
